k2_run_controller: RTL and testbench

//  Sequencer for the 8-bit K2 core: owns the 16x8 program store, loads it over a valid/ready stream,

---
 rtl/k2_run_controller.sv | 169 ++++++++++++++++
 tb/tb_k2_run_controller.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/k2_run_controller.sv
// K2 run controller: owns the program store, loads it from a valid/ready stream and
// sequences the core through run/step/halt. Optional breakpoint logic: K2_RUN_CTRL_BREAKPOINT_EN.
module k2_run_controller #(
  parameter int ADDR_W   = 4,
  parameter int INSTR_W  = 8,
  parameter int BUDGET_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_valid,
  output logic                load_ready,
  input  logic [INSTR_W-1:0]  load_data,
  input  logic                load_last,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [BUDGET_W-1:0] run_budget,
  input  logic [ADDR_W-1:0]   pc_i,
  output logic [INSTR_W-1:0]  instr_o,
  output logic                core_rst,
  output logic                core_en,
  output logic [2:0]          state_o,
  output logic                done,
  output logic [BUDGET_W-1:0] cycle_cnt,
  output logic [ADDR_W:0]     load_count
`ifdef K2_RUN_CTRL_BREAKPOINT_EN
  ,
  input  logic                bp_valid,
  input  logic [ADDR_W-1:0]   bp_addr,
  output logic                bp_hit
`endif
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [1:0] OP_RUN = 2'd0, OP_STEP = 2'd1, OP_HALT = 2'd2, OP_CLEAR = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_READY  = 3'd2,
    ST_RUN    = 3'd3,
    ST_STEP   = 3'd4,
    ST_HALTED = 3'd5
  } state_e;

  state_e               state_q, state_d, st;
  logic [INSTR_W-1:0]   mem_q [DEPTH];
  logic [ADDR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]      lcnt_q, lcnt_d;
  logic [BUDGET_W-1:0]  cyc_q, cyc_d, bud_q, bud_d;
  logic                 done_q, done_d;
  logic                 mem_we, load_acc, cmd_acc, bp_stall;

  // Encodings outside the enum behave as IDLE.
  always_comb begin
    st = ST_IDLE;
    case (state_q)
      ST_IDLE, ST_LOAD, ST_READY, ST_RUN, ST_STEP, ST_HALTED: st = state_q;
      default: st = ST_IDLE;
    endcase
  end

`ifdef K2_RUN_CTRL_BREAKPOINT_EN
  logic resume_q;
  // Set only in the first RUN cycle after HALTED so a resume executes the breakpointed word.
  always_ff @(posedge clk) begin
    if (rst) resume_q <= 1'b0;
    else     resume_q <= (st == ST_HALTED) && cmd_acc && (cmd_op == OP_RUN);
  end
  assign bp_stall = (st == ST_RUN) && bp_valid && (pc_i == bp_addr) && !resume_q;
  assign bp_hit   = bp_stall;
`else
  assign bp_stall = 1'b0;
`endif

  assign load_ready = (st == ST_IDLE) || (st == ST_LOAD);
  assign cmd_ready  = (st == ST_READY) || (st == ST_RUN) || (st == ST_HALTED);
  assign core_rst   = (st == ST_IDLE) || (st == ST_LOAD) || (st == ST_READY);
  assign core_en    = (st == ST_STEP) || ((st == ST_RUN) && !bp_stall);
  assign load_acc   = load_valid && load_ready;
  assign cmd_acc    = cmd_valid && cmd_ready;

  assign instr_o    = mem_q[pc_i];
  assign state_o    = st;
  assign done       = done_q;
  assign cycle_cnt  = cyc_q;
  assign load_count = lcnt_q;

  always_comb begin
    state_d  = st;
    wr_ptr_d = wr_ptr_q;
    lcnt_d   = lcnt_q;
    cyc_d    = cyc_q;
    bud_d    = bud_q;
    done_d   = 1'b0;
    mem_we   = 1'b0;
    if (core_en && (cyc_q != '1)) cyc_d = cyc_q + 1'b1;
    case (st)
      ST_IDLE, ST_LOAD: begin
        if (load_acc) begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          lcnt_d   = lcnt_q + 1'b1;
          state_d  = (load_last || (wr_ptr_q == '1)) ? ST_READY : ST_LOAD;
        end
      end
      ST_READY: begin
        if (cmd_acc) begin
          case (cmd_op)
            OP_RUN:   begin state_d = ST_RUN;  bud_d = run_budget; cyc_d = '0; end
            OP_STEP:  begin state_d = ST_STEP; cyc_d = '0; end
            OP_CLEAR: begin state_d = ST_IDLE; wr_ptr_d = '0; lcnt_d = '0; end
            default:  ;
          endcase
        end
      end
      ST_RUN: begin
        if (core_en && (bud_q != '0)) begin
          bud_d = bud_q - 1'b1;
          if (bud_q == BUDGET_W'(1)) begin
            state_d = ST_HALTED;
            done_d  = 1'b1;
          end
        end
        if (bp_stall) state_d = ST_HALTED;
        if (cmd_acc && (cmd_op == OP_HALT)) state_d = ST_HALTED;
        if (cmd_acc && (cmd_op == OP_CLEAR)) begin
          state_d  = ST_IDLE;
          wr_ptr_d = '0;
          lcnt_d   = '0;
          done_d   = 1'b0;
        end
      end
      ST_STEP: state_d = ST_HALTED;
      ST_HALTED: begin
        if (cmd_acc) begin
          case (cmd_op)
            OP_RUN:   begin state_d = ST_RUN; bud_d = run_budget; end
            OP_STEP:  state_d = ST_STEP;
            OP_CLEAR: begin state_d = ST_IDLE; wr_ptr_d = '0; lcnt_d = '0; end
            default:  ;
          endcase
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      lcnt_q   <= '0;
      cyc_q    <= '0;
      bud_q    <= '0;
      done_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      lcnt_q   <= lcnt_d;
      cyc_q    <= cyc_d;
      bud_q    <= bud_d;
      done_q   <= done_d;
      if (mem_we) mem_q[wr_ptr_q] <= load_data;
    end
  end

endmodule

// File: tb/tb_k2_run_controller.sv
// Scoreboard bench for k2_run_controller: stimulus queues expected observations,
// a negedge monitor pops and compares them and counts core_en/done pulses.
module tb_k2_run_controller;
  localparam int AW = 4, IW = 8, BW = 16;
  localparam logic [1:0] RUN = 2'd0, STEP = 2'd1, HALT = 2'd2, CLEAR = 2'd3;

  logic          clk = 1'b0, rst = 1'b1;
  logic          load_valid = 1'b0, load_ready, load_last = 1'b0;
  logic [IW-1:0] load_data = '0;
  logic          cmd_valid = 1'b0, cmd_ready;
  logic [1:0]    cmd_op = '0;
  logic [BW-1:0] run_budget = '0;
  logic [AW-1:0] pc_i = '0;
  logic [IW-1:0] instr_o;
  logic          core_rst, core_en, done;
  logic [2:0]    state_o;
  logic [BW-1:0] cycle_cnt;
  logic [AW:0]   load_count;
`ifdef K2_RUN_CTRL_BREAKPOINT_EN
  logic          bp_valid = 1'b0, bp_hit;
  logic [AW-1:0] bp_addr = '0;
`endif

  always #5 clk = ~clk;

  k2_run_controller #(.ADDR_W(AW), .INSTR_W(IW), .BUDGET_W(BW)) dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data), .load_last(load_last),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .run_budget(run_budget),
    .pc_i(pc_i), .instr_o(instr_o), .core_rst(core_rst), .core_en(core_en),
    .state_o(state_o), .done(done), .cycle_cnt(cycle_cnt), .load_count(load_count)
`ifdef K2_RUN_CTRL_BREAKPOINT_EN
    , .bp_valid(bp_valid), .bp_addr(bp_addr), .bp_hit(bp_hit)
`endif
  );

  typedef enum int {S_STATE, S_LRDY, S_CRDY, S_CRST, S_CEN, S_DONE, S_CYC, S_LCNT,
                    S_INSTR, S_ENCNT, S_DONECNT, S_BPHIT, S_CLR} sel_e;
  typedef struct {
    sel_e        sel;
    logic [31:0] exp;
    string       nm;
  } chk_t;

  chk_t sb[$];
  int   n_tests = 0, n_fail = 0, en_cnt = 0, done_cnt = 0;

  function automatic logic [31:0] observe(sel_e s);
    case (s)
      S_STATE:   return 32'(state_o);
      S_LRDY:    return 32'(load_ready);
      S_CRDY:    return 32'(cmd_ready);
      S_CRST:    return 32'(core_rst);
      S_CEN:     return 32'(core_en);
      S_DONE:    return 32'(done);
      S_CYC:     return 32'(cycle_cnt);
      S_LCNT:    return 32'(load_count);
      S_INSTR:   return 32'(instr_o);
      S_ENCNT:   return 32'(en_cnt);
      S_DONECNT: return 32'(done_cnt);
`ifdef K2_RUN_CTRL_BREAKPOINT_EN
      S_BPHIT:   return 32'(bp_hit);
`endif
      default:   return 32'hdead_beef;
    endcase
  endfunction

  // Monitor: count pulses first, then settle every observation queued this cycle.
  always @(negedge clk) begin
    chk_t it;
    logic [31:0] act;
    if (core_en === 1'b1) en_cnt++;
    if (done === 1'b1) done_cnt++;
    while (sb.size() > 0) begin
      it = sb.pop_front();
      if (it.sel == S_CLR) begin
        en_cnt   = 0;
        done_cnt = 0;
      end else begin
        act = observe(it.sel);
        n_tests++;
        if (act !== it.exp) begin
          n_fail++;
          $display("FAIL %s: got %0h, expected %0h", it.nm, act, it.exp);
        end
      end
    end
  end

  task automatic want(input sel_e s, input logic [31:0] e, input string nm);
    sb.push_back('{s, e, nm});
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [IW-1:0] d, input logic last);
    load_valid = 1'b1; load_data = d; load_last = last;
    cyc();
    load_valid = 1'b0; load_last = 1'b0;
  endtask

  task automatic issue_cmd(input logic [1:0] op, input logic [BW-1:0] b);
    cmd_valid = 1'b1; cmd_op = op; run_budget = b;
    cyc();
    cmd_valid = 1'b0;
  endtask

  task automatic chk_instr(input logic [AW-1:0] p, input logic [IW-1:0] e, input string nm);
    pc_i = p;
    want(S_INSTR, 32'(e), nm);
    cyc();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    want(S_STATE, 0, "rst_state");  want(S_LRDY, 1, "rst_load_ready");
    want(S_CRDY, 0, "rst_cmd_ready"); want(S_CRST, 1, "rst_core_rst");
    want(S_CEN, 0, "rst_core_en");   want(S_DONE, 0, "rst_done");
    want(S_CYC, 0, "rst_cycle_cnt"); want(S_LCNT, 0, "rst_load_count");
    want(S_INSTR, 0, "rst_instr");
    cyc();

    // three-word program with load_last
    load(8'h11, 1'b0); load(8'h22, 1'b0); load(8'h33, 1'b1);
    want(S_STATE, 2, "ld3_state"); want(S_LCNT, 3, "ld3_count");
    want(S_LRDY, 0, "ld3_load_ready"); want(S_CRDY, 1, "ld3_cmd_ready");
    chk_instr(0, 8'h11, "ld3_mem0"); chk_instr(1, 8'h22, "ld3_mem1"); chk_instr(2, 8'h33, "ld3_mem2");

    // reset in the middle of a load
    issue_cmd(CLEAR, '0);
    want(S_STATE, 0, "clr_state"); want(S_LCNT, 0, "clr_count");
    load(8'hAA, 1'b0); load(8'hBB, 1'b0);
    want(S_STATE, 1, "part_state"); want(S_LCNT, 2, "part_count");
    chk_instr(1, 8'hBB, "part_mem1");
    rst = 1'b1; cyc(); rst = 1'b0;
    want(S_STATE, 0, "mrst_state"); want(S_LCNT, 0, "mrst_count"); want(S_LRDY, 1, "mrst_load_ready");
    chk_instr(0, 8'h00, "mrst_mem0"); chk_instr(1, 8'h00, "mrst_mem1"); chk_instr(2, 8'h00, "mrst_mem2");

    // full 16-word load without load_last
    for (int i = 0; i < 16; i++) begin
      load(8'h40 + 8'(i), 1'b0);
      if (i == 14) want(S_STATE, 1, "full15_state");
    end
    want(S_STATE, 2, "full_state"); want(S_LCNT, 16, "full_count"); want(S_LRDY, 0, "full_load_ready");
    load_valid = 1'b1; load_data = 8'hEE;
    want(S_LRDY, 0, "extra_load_ready");
    cyc();
    load_valid = 1'b0;
    want(S_LCNT, 16, "extra_count");
    chk_instr(0, 8'h40, "full_mem0"); chk_instr(15, 8'h4F, "full_mem15");

    // RUN with budget 5
    want(S_CLR, 0, "");
    issue_cmd(RUN, 16'd5);
    want(S_STATE, 3, "b5_state"); want(S_CEN, 1, "b5_en_first");
    repeat (4) cyc();
    want(S_CEN, 1, "b5_en_last"); want(S_STATE, 3, "b5_state_last");
    cyc();
    want(S_STATE, 5, "b5_halted"); want(S_DONE, 1, "b5_done"); want(S_CEN, 0, "b5_en_off");
    want(S_CRST, 0, "b5_core_rst");
    cyc();
    want(S_DONE, 0, "b5_done_drop"); want(S_ENCNT, 5, "b5_en_cycles");
    want(S_DONECNT, 1, "b5_done_pulses"); want(S_CYC, 5, "b5_cycle_cnt");

    // three single steps, then CLEAR
    want(S_CLR, 0, "");
    for (int k = 0; k < 3; k++) begin
      issue_cmd(STEP, '0);
      want(S_STATE, 4, "step_state"); want(S_CEN, 1, "step_en");
      cyc();
      want(S_STATE, 5, "step_halted"); want(S_CEN, 0, "step_en_off");
    end
    want(S_CYC, 8, "step_cycle_cnt"); want(S_ENCNT, 3, "step_en_cycles"); want(S_DONECNT, 0, "step_done");
    issue_cmd(CLEAR, '0);
    want(S_STATE, 0, "sclr_state"); want(S_CRST, 1, "sclr_core_rst");
    want(S_LCNT, 0, "sclr_count"); want(S_LRDY, 1, "sclr_load_ready");
    chk_instr(3, 8'h43, "sclr_mem_kept");

    // unlimited RUN stopped by HALT, with a no-op RUN in between
    load(8'h99, 1'b1);
    want(S_STATE, 2, "reload_state"); want(S_LCNT, 1, "reload_count");
    chk_instr(0, 8'h99, "reload_mem0"); chk_instr(1, 8'h41, "reload_mem1_kept");
    want(S_CLR, 0, "");
    issue_cmd(RUN, 16'd0);
    cyc();
    issue_cmd(RUN, 16'd2);
    repeat (5) cyc();
    want(S_CEN, 1, "halt_accept_en"); want(S_STATE, 3, "halt_accept_state"); want(S_CRDY, 1, "halt_cmd_ready");
    issue_cmd(HALT, '0);
    want(S_STATE, 5, "halt_state"); want(S_CEN, 0, "halt_en_off");
    cyc();
    want(S_CYC, 8, "halt_cycle_cnt"); want(S_ENCNT, 8, "halt_en_cycles"); want(S_DONECNT, 0, "halt_done");

`ifdef K2_RUN_CTRL_BREAKPOINT_EN
    // breakpoint at 4, then resume through it
    pc_i = 4'd3; bp_valid = 1'b1; bp_addr = 4'd4;
    want(S_CLR, 0, "");
    issue_cmd(RUN, 16'd0);
    want(S_CEN, 1, "bp_run_en"); want(S_BPHIT, 0, "bp_run_nohit");
    cyc();
    pc_i = 4'd4;
    want(S_CEN, 0, "bp_stall_en"); want(S_BPHIT, 1, "bp_hit"); want(S_STATE, 3, "bp_stall_state");
    cyc();
    want(S_STATE, 5, "bp_halted"); want(S_BPHIT, 0, "bp_hit_drop"); want(S_CEN, 0, "bp_halted_en");
    issue_cmd(RUN, 16'd0);
    want(S_CEN, 1, "bp_resume_en"); want(S_BPHIT, 0, "bp_resume_nohit"); want(S_STATE, 3, "bp_resume_state");
    issue_cmd(HALT, '0);
    want(S_STATE, 5, "bp_final_state"); want(S_ENCNT, 2, "bp_en_cycles"); want(S_CYC, 10, "bp_cycle_cnt");
    bp_valid = 1'b0;
`endif

    repeat (2) cyc();
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
